// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus: requester handshake, shared ROM port
// and tagged read responses back to the requesters.
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       rom_addr;
    logic                    rom_rd;
    logic [DATA_W-1:0]       rom_dout;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        output req, req_addr, rom_dout,
        input  gnt, rom_addr, rom_rd,
        input  rsp_valid, rsp_data
    );

    modport slave (
        input  req, req_addr, rom_dout,
        output gnt, rom_addr, rom_rd,
        output rsp_valid, rsp_data
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM port,
// returning read data tagged to the requester after a fixed latency.
module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 2
) (
    input logic                Clk,
    input logic                Reset,
    sprite_rom_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);
    localparam logic [PW:0] NR = (PW+1)'(N_REQ);

    logic [PW-1:0]     ptr;
    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [N_REQ-1:0]  gnt_c;
    logic [PW-1:0]     sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              rom_rd_q;
    logic [N_REQ-1:0]  tag_q [ROM_LAT+1];
    logic [N_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    // Unpack the flat requester address bus
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Search from ptr upward with wrap; first asserted request wins
    always_comb begin
        logic [PW:0] idx;
        gnt_c    = '0;
        sel      = ptr;
        sel_addr = rom_addr_q;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= NR) begin
                idx = idx - NR;
            end
            if (gnt_c == '0 && bus.req[idx[PW-1:0]]) begin
                gnt_c[idx[PW-1:0]] = 1'b1;
                sel                = idx[PW-1:0];
                sel_addr           = addr_arr[idx[PW-1:0]];
            end
        end
        if (Reset) begin
            gnt_c = '0;
        end
    end

    // Priority pointer moves just past each granted requester
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= '0;
        end else if (|gnt_c) begin
            ptr <= (sel == LAST) ? '0 : sel + 1'b1;
        end
    end

    // Issue stage: register the winning address onto the ROM port
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q <= '0;
            rom_rd_q   <= 1'b0;
        end else begin
            rom_rd_q <= |gnt_c;
            if (|gnt_c) begin
                rom_addr_q <= sel_addr;
            end
        end
    end

    // Tag pipeline tracks the owner of each in-flight read
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= gnt_c;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Response stage: capture ROM data when a tag arrives, else hold
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= tag_q[ROM_LAT];
            if (|tag_q[ROM_LAT]) begin
                rsp_data_q <= bus.rom_dout;
            end
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_rd    = rom_rd_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios then random traffic,
// checked against a cycle-level round-robin and response-queue model.
module tb_sprite_rom_arbiter;
    parameter int ROM_LAT = 2;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;

    logic Clk;
    logic Reset;

    sprite_rom_arbiter_if #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) bus ();

    sprite_rom_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    typedef struct {
        int               due;
        logic [N_REQ-1:0] v;
        logic [DATA_W-1:0] d;
    } rsp_t;

    rsp_t              exp_q[$];
    int                m_ptr;
    logic              m_rd;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              pend [N_REQ];
    logic [ADDR_W-1:0] a_r [N_REQ];
    int                cyc;
    int                checks;
    int                passes;
    logic [ADDR_W-1:0] rom_pipe [ROM_LAT];

    function automatic logic [DATA_W-1:0] rom_f(
        input logic [ADDR_W-1:0] a);
        return DATA_W'({a, 5'h15}) ^ 24'h5A3C96;
    endfunction

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Synchronous ROM with ROM_LAT cycles from address to data
    always @(posedge Clk) begin
        rom_pipe[0] <= bus.rom_addr;
        for (int i = 1; i < ROM_LAT; i++) begin
            rom_pipe[i] <= rom_pipe[i-1];
        end
    end

    assign bus.rom_dout = rom_f(rom_pipe[ROM_LAT-1]);

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h",
                    tag, cyc, obs, exp);
    endtask

    task automatic cycle(input logic rst);
        logic [N_REQ-1:0]        r;
        logic [N_REQ*ADDR_W-1:0] ad;
        logic [N_REQ-1:0]        eg;
        logic [N_REQ-1:0]        ev;
        rsp_t                    e;
        int                      w;
        int                      j;
        for (int i = 0; i < N_REQ; i++) begin
            r[i] = pend[i];
            ad[i*ADDR_W +: ADDR_W] = a_r[i];
        end
        Reset        = rst;
        bus.req      = r;
        bus.req_addr = ad;
        @(negedge Clk);
        w = -1;
        if (!rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                j = (m_ptr + k) % N_REQ;
                if (w < 0 && r[j]) w = j;
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        ev = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev     = exp_q[0].v;
            m_data = exp_q[0].d;
            void'(exp_q.pop_front());
        end
        chk("gnt", 64'(bus.gnt), 64'(eg));
        chk("rom_rd", 64'(bus.rom_rd), 64'(m_rd));
        chk("rom_addr", 64'(bus.rom_addr), 64'(m_addr));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
        chk("rsp_data", 64'(bus.rsp_data), 64'(m_data));
        if (rst) begin
            m_ptr  = 0;
            m_rd   = 1'b0;
            m_addr = '0;
            m_data = '0;
            exp_q.delete();
        end else if (w >= 0) begin
            m_rd   = 1'b1;
            m_addr = a_r[w];
            e.due  = cyc + 2 + ROM_LAT;
            e.v    = eg;
            e.d    = rom_f(a_r[w]);
            exp_q.push_back(e);
            m_ptr  = (w + 1) % N_REQ;
            pend[w] = 1'b0;
        end else begin
            m_rd = 1'b0;
        end
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        passes = 0;
        m_ptr  = 0;
        m_rd   = 1'b0;
        m_addr = '0;
        m_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1'b0;
            a_r[i]  = '0;
        end
        Reset        = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        @(posedge Clk);
        #1;

        // reset state, with a request held to see gnt forced low
        pend[3] = 1'b1;
        a_r[3]  = 19'h00abc;
        cycle(1'b1);
        cycle(1'b1);
        pend[3] = 1'b0;
        cycle(1'b1);

        // single read from requester 2
        pend[2] = 1'b1;
        a_r[2]  = 19'h00123;
        cycle(1'b0);
        idle(ROM_LAT + 4);

        // all requesters continuously after reset
        cycle(1'b1);
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i]) begin
                    pend[i] = 1'b1;
                    a_r[i]  = ADDR_W'($urandom);
                end
            end
            cycle(1'b0);
        end
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
        idle(ROM_LAT + 4);

        // fairness after skip: ptr=1, req 0 and 3
        cycle(1'b1);
        pend[0] = 1'b1;
        a_r[0]  = 19'h00040;
        cycle(1'b0);
        pend[0] = 1'b1;
        a_r[0]  = 19'h00041;
        pend[3] = 1'b1;
        a_r[3]  = 19'h00043;
        cycle(1'b0);
        cycle(1'b0);
        idle(2);
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1'b1;
            a_r[i]  = ADDR_W'(19'h00200 + i);
        end
        idle(N_REQ);
        idle(ROM_LAT + 4);

        // back-to-back single requester
        pend[1] = 1'b1;
        a_r[1]  = 19'h00010;
        cycle(1'b0);
        pend[1] = 1'b1;
        a_r[1]  = 19'h00011;
        cycle(1'b0);
        pend[1] = 1'b1;
        a_r[1]  = 19'h00012;
        cycle(1'b0);
        idle(ROM_LAT + 4);

        // reset while a read is in flight
        pend[2] = 1'b1;
        a_r[2]  = 19'h00005;
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        idle(ROM_LAT + 3);
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1'b1;
            a_r[i]  = ADDR_W'(19'h00300 + i);
        end
        idle(N_REQ);
        idle(ROM_LAT + 4);

        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    a_r[i]  = ADDR_W'($urandom);
                end
            end
            cycle($urandom_range(0, 59) == 0);
        end
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
        idle(ROM_LAT + 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
